binary_to_ohc_7: RTL and testbench

Streaming converter from 3-bit binary residues (mod 7) to 7-bit one-hot code (OHC), the inverse of the OHC-to-binary decode used at the output of the mod-7 RNS adder channel. It sits at the input of the mod-7 OHC adder path, accepting binary residues under a valid/ready handshake and buffering converted codes in a 2-entry output queue so that back-pressure does not drop data. Out-of-range inputs (value 7) are flagged per word and counted.

---
 rtl/binary_to_ohc_7.sv | 104 ++++++++++
 tb/tb_binary_to_ohc_7.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/binary_to_ohc_7.sv
// binary_to_ohc_7: converts 3-bit mod-7 residues to 7-bit one-hot codes.
// The converted words are buffered in a 2-entry FIFO so that back-pressure
// from the adder path never drops a residue. Illegal inputs (value 7) become
// an all-zero code with an error flag, and a saturating counter counts them.
module binary_to_ohc_7 #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6:0]           out_ohc,
    output logic                 out_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Stored word layout: {ohc[6:0], err}
    logic [7:0] head;
    logic [7:0] tail;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic [7:0] in_word;
    logic       in_illegal;

    // Residue to {one-hot, error} word; value 7 has no one-hot image.
    function automatic logic [7:0] convert(input logic [2:0] bin);
        logic [6:0] ohc;
        if (bin == 3'd7) begin
            ohc = 7'd0;
        end else begin
            ohc = 7'(32'd1 << bin);
        end
        return {ohc, (bin == 3'd7)};
    endfunction

    // Saturating increment: holds at the all-ones value instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] val);
        if (val == {ERR_CNT_W{1'b1}}) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    // Handshake decode; in_ready depends on occupancy only, never on in_valid.
    always_comb begin
        in_ready   = rst_n && (count < 2'd2);
        out_valid  = (count != 2'd0);
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        in_word    = convert(in_bin);
        in_illegal = (in_bin == 3'd7);
        out_ohc    = out_valid ? head[7:1] : 7'd0;
        out_err    = out_valid ? head[0]   : 1'b0;
    end

    // Two-slot queue: head is the word on the output, tail the one behind it.
    // Push together with pop can only happen at count 1, so the new word
    // goes straight to the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 8'd0;
            tail  <= 8'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= in_word;
                    end else begin
                        tail <= in_word;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= 8'd0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    head <= in_word;
                end
                default: begin
                end
            endcase
        end
    end

    // Illegal-input counter; a clear coinciding with an illegal push leaves 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= (push && in_illegal) ? ERR_CNT_W'(1) : '0;
        end else if (push && in_illegal) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule

// File: tb/tb_binary_to_ohc_7.sv
// Bench for binary_to_ohc_7: directed scenarios plus random traffic, checked
// against a queue-based reference model of the converter.
module tb_binary_to_ohc_7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_bin = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] out_ohc;
    logic       out_err;
    logic       err_clr = 1'b0;
    logic [7:0] err_count;

    // Narrow-counter instance for the saturation scenario
    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [2:0] s_in_bin = 3'd0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic [6:0] s_out_ohc;
    logic       s_out_err;
    logic       s_err_clr = 1'b0;
    logic [1:0] s_err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int         e_mod = 0;

    binary_to_ohc_7 #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_bin(in_bin), .out_valid(out_valid), .out_ready(out_ready),
        .out_ohc(out_ohc), .out_err(out_err), .err_clr(err_clr),
        .err_count(err_count)
    );

    binary_to_ohc_7 #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_bin(s_in_bin), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ohc(s_out_ohc), .out_err(s_out_err), .err_clr(s_err_clr),
        .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference word for a residue: bit k for k in 0..6, zero code plus error for 7.
    function automatic logic [7:0] ref_word(input int b);
        int ohc;
        ohc = (b == 7) ? 0 : (1 << b);
        return {ohc[6:0], (b == 7)};
    endfunction

    task automatic check_outs();
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_ohc", out_ohc, (q.size() > 0) ? q[0][7:1] : 7'd0);
        chk("out_err", out_err, (q.size() > 0) ? q[0][0] : 1'b0);
        chk("err_count", err_count, e_mod);
    endtask

    // Check current outputs, advance one clock, update the model.
    task automatic step();
        bit         do_push;
        bit         do_pop;
        logic [7:0] w;
        check_outs();
        do_push = in_valid && (q.size() < 2);
        do_pop  = out_ready && (q.size() > 0);
        w       = ref_word(int'(in_bin));
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(w);
        if (err_clr) e_mod = (do_push && in_bin == 3'd7) ? 1 : 0;
        else if (do_push && in_bin == 3'd7 && e_mod < 255) e_mod++;
        #1;
    endtask

    task automatic drive(input bit v, input int b, input bit r);
        in_valid  = v;
        in_bin    = 3'(b);
        out_ready = r;
        step();
    endtask

    initial begin
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_ohc", out_ohc, 7'd0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_sat_count", s_err_count, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sweep of all legal residues at full throughput
        for (int k = 0; k < 7; k++) drive(1'b1, k, 1'b1);
        repeat (2) drive(1'b0, 0, 1'b1);

        // Illegal value followed by a legal one
        drive(1'b1, 7, 1'b1);
        drive(1'b1, 3, 1'b1);
        repeat (2) drive(1'b0, 0, 1'b1);

        // Back-pressure: 6 waits while the queue is full
        drive(1'b1, 2, 1'b0);
        drive(1'b1, 5, 1'b0);
        repeat (3) drive(1'b1, 6, 1'b0);
        drive(1'b1, 6, 1'b1);
        drive(1'b1, 6, 1'b1);
        repeat (3) drive(1'b0, 0, 1'b1);

        // Saturation and clear on the 2-bit counter instance
        s_in_valid = 1'b1;
        s_in_bin   = 3'd7;
        repeat (3) drive(1'b0, 0, 1'b1);
        chk("sat_reach", s_err_count, 2'd3);
        repeat (2) drive(1'b0, 0, 1'b1);
        chk("sat_hold", s_err_count, 2'd3);
        s_err_clr = 1'b1;
        drive(1'b0, 0, 1'b1);
        chk("sat_clr_push", s_err_count, 2'd1);
        chk("sat_out_err", s_out_err, 1'b1);
        chk("sat_out_ohc", s_out_ohc, 7'd0);
        s_in_valid = 1'b0;
        drive(1'b0, 0, 1'b1);
        chk("sat_clr_only", s_err_count, 2'd0);
        s_err_clr = 1'b0;

        // Reset in the middle of a cycle with two words queued
        drive(1'b1, 7, 1'b0);
        drive(1'b1, 1, 1'b0);
        in_valid = 1'b0;
        check_outs();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        e_mod = 0;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_ohc", out_ohc, 7'd0);
        chk("mid_rst_out_err", out_err, 1'b0);
        chk("mid_rst_err_count", err_count, 8'd0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 4, 1'b1);
        chk("post_rst_ohc", out_ohc, 7'b0010000);
        drive(1'b0, 0, 1'b1);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            err_clr = ($urandom_range(0, 63) == 0);
            drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 2) != 0));
        end
        err_clr = 1'b0;
        repeat (3) drive(1'b0, 0, 1'b1);
        check_outs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
